seq_detect_param: RTL

Parametrised serial bit-pattern detector. It generalises the fixed 3-bit "011" detector to any PAT_W-bit pattern. The pattern and the overlap mode are programmable at run time, and the input stream is valid-qualified. It sits on a serial stream inside the datapath and emits a one-cycle match pulse, plus an optional saturating match count.

---
 rtl/seq_detect_param.sv | 127 ++++++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: run-time programmable PAT_W-bit serial pattern detector.
// Optional saturating match counter built only when MATCH_CNT_EN is defined.
//
// Ports:
//   sysclk       clock, rising edge
//   reset        synchronous active-high reset
//   stream       serial data bit
//   stream_valid qualifies stream
//   cfg_load     strobe: load cfg_pattern/cfg_overlap, clear history
//   cfg_pattern  pattern, MSB is the first bit in time
//   cfg_overlap  1 = overlapping matches allowed
//   y            registered one-cycle match pulse
//   armed        PAT_W bits collected since last clear
//   match_cnt    saturating match count (zero without MATCH_CNT_EN)
module seq_detect_param #(
  parameter int PAT_W = 3,
  parameter logic [PAT_W-1:0] RESET_PATTERN = PAT_W'(3'b011),
  parameter logic RESET_OVERLAP = 1'b0,
  parameter int MATCH_CNT_W = 8
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   stream,
  input  logic                   stream_valid,
  input  logic                   cfg_load,
  input  logic [PAT_W-1:0]       cfg_pattern,
  input  logic                   cfg_overlap,
  output logic                   y,
  output logic                   armed,
  output logic [MATCH_CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  typedef enum logic {
    S_FILL,
    S_ARMED
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [PAT_W-1:0] pattern_reg;
  logic             overlap_reg;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_d;
  logic [PAT_W-1:0] hist_sh;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_d;
  logic [FW-1:0]    fill_inc;
  logic             hit;
  logic             y_d;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      pattern_reg <= RESET_PATTERN;
      overlap_reg <= RESET_OVERLAP;
      hist        <= '0;
      fill        <= '0;
      state       <= S_FILL;
      y           <= 1'b0;
    end else begin
      if (cfg_load) begin
        pattern_reg <= cfg_pattern;
        overlap_reg <= cfg_overlap;
      end
      hist  <= hist_d;
      fill  <= fill_d;
      state <= state_n;
      y     <= y_d;
    end
  end

  always_comb begin
    hist_sh  = {hist[PAT_W-2:0], stream};
    fill_inc = (fill == FULL) ? FULL
                              : fill + FW'(1);
    // fill gate stops a stale all-zero history
    // from matching before PAT_W real bits arrive
    hit      = (fill_inc == FULL)
            && (hist_sh == pattern_reg);
    state_n  = state;
    hist_d   = hist;
    fill_d   = fill;
    y_d      = 1'b0;
    unique case (1'b1)
      cfg_load: begin
        hist_d  = '0;
        fill_d  = '0;
        state_n = S_FILL;
      end
      stream_valid && !cfg_load: begin
        y_d = hit;
        if (hit && !overlap_reg) begin
          hist_d  = '0;
          fill_d  = '0;
          state_n = S_FILL;
        end else begin
          hist_d  = hist_sh;
          fill_d  = fill_inc;
          state_n = (fill_inc == FULL) ? S_ARMED
                                       : S_FILL;
        end
      end
      default: ;
    endcase
  end

  assign armed = (state == S_ARMED);

`ifdef MATCH_CNT_EN
  logic [MATCH_CNT_W-1:0] cnt;

  always_ff @(posedge sysclk) begin
    if (reset || cfg_load) begin
      cnt <= '0;
    end else if (y_d && (cnt != '1)) begin
      cnt <= cnt + MATCH_CNT_W'(1);
    end
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule
